// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide unit for the execute stage.
// Radix-2 Booth multiply and non-restoring divide, fixed 33-cycle latency.
module multdiv_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t state;
    state_t state_next;

    logic [5:0]         count;
    logic signed [33:0] acc;      // MUL: Booth high half in [32:0]; DIV: partial remainder
    logic [31:0]        lo;       // MUL: multiplier / low product; DIV: dividend out, quotient in
    logic               qm1;
    logic signed [32:0] mcand;    // MUL: sign-extended multiplicand; DIV: divisor magnitude
    logic               q_neg;
    logic               div_zero;
    logic               div_ovf;

    logic        start_mul;
    logic        start_div;
    logic        iter_done;
    logic [65:0] booth_nxt;
    logic [65:0] div_nxt;
    logic [32:0] mul_fin;
    logic [32:0] div_fin;

    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    // Returns {new_hi[32:0], new_lo[31:0], new_qm1} after one add/sub and arithmetic shift.
    function automatic logic [65:0] booth_step(input logic signed [32:0] hi,
                                               input logic [31:0]        lo_in,
                                               input logic               q,
                                               input logic signed [32:0] m);
        logic signed [32:0] sum;
        case ({lo_in[0], q})
            2'b01:   sum = hi + m;
            2'b10:   sum = hi - m;
            default: sum = hi;
        endcase
        return {sum[32], sum, lo_in};
    endfunction

    // Returns {new_rem[33:0], new_q[31:0]}; quotient bit is 1 when the new remainder is non-negative.
    function automatic logic [65:0] div_step(input logic signed [33:0] r,
                                             input logic [31:0]        q,
                                             input logic signed [32:0] d);
        logic signed [33:0] shifted;
        logic signed [33:0] dd;
        logic signed [33:0] nr;
        shifted = {r[32:0], q[31]};
        dd      = {d[32], d};
        if (!r[33])
            nr = shifted - dd;
        else
            nr = shifted + dd;
        return {nr, q[30:0], ~nr[33]};
    endfunction

    // {exception, low word}: overflow when the high word is not the sign extension of the low word.
    function automatic logic [32:0] mul_finish(input logic [31:0] hi, input logic [31:0] low);
        return {(hi != {32{low[31]}}), low};
    endfunction

    function automatic logic [32:0] div_finish(input logic [31:0] q,
                                               input logic        neg,
                                               input logic        zero,
                                               input logic        ovf);
        if (zero)
            return {1'b1, 32'h0000_0000};
        else if (ovf)
            return {1'b1, 32'h8000_0000};
        else
            return {1'b0, neg ? (~q + 32'd1) : q};
    endfunction

    assign start_mul = ctrl_MULT;
    assign start_div = ctrl_DIV & ~ctrl_MULT;
    assign iter_done = (count == 6'd32);

    assign booth_nxt = booth_step($signed(acc[32:0]), lo, qm1, mcand);
    assign div_nxt   = div_step(acc, lo, mcand);
    assign mul_fin   = mul_finish(acc[31:0], lo);
    assign div_fin   = div_finish(lo, q_neg, div_zero, div_ovf);

    assign busy           = (state == MUL) || (state == DIV);
    assign data_resultRDY = (state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A new start always wins, even over completion in the final cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     state_next = IDLE;
            MUL, DIV: if (iter_done) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        if (start_mul)
            state_next = MUL;
        else if (start_div)
            state_next = DIV;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count          <= 6'd0;
            acc            <= '0;
            lo             <= '0;
            qm1            <= 1'b0;
            mcand          <= '0;
            q_neg          <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
        end else if (start_mul) begin
            count    <= 6'd0;
            acc      <= '0;
            lo       <= data_operandB;
            qm1      <= 1'b0;
            mcand    <= {data_operandA[31], data_operandA};
            q_neg    <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
        end else if (start_div) begin
            count    <= 6'd0;
            acc      <= '0;
            lo       <= magnitude(data_operandA);
            qm1      <= 1'b0;
            mcand    <= {1'b0, magnitude(data_operandB)};
            q_neg    <= data_operandA[31] ^ data_operandB[31];
            div_zero <= (data_operandB == 32'd0);
            div_ovf  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
        end else if (busy && !iter_done) begin
            count <= count + 6'd1;
            if (state == MUL) begin
                acc <= {booth_nxt[65], booth_nxt[65:33]};
                lo  <= booth_nxt[32:1];
                qm1 <= booth_nxt[0];
            end else begin
                acc <= div_nxt[65:32];
                lo  <= div_nxt[31:0];
            end
        end else if (busy) begin
            if (state == MUL) begin
                data_result    <= mul_fin[31:0];
                data_exception <= mul_fin[32];
            end else begin
                data_result    <= div_fin[31:0];
                data_exception <= div_fin[32];
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: stimulus pushes expected results, a negedge monitor checks them.
module tb_multdiv_unit;

    logic        clk;
    logic        rst;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        mult;
    logic        div;
    logic [31:0] res;
    logic        exc;
    logic        rdy;
    logic        busy;

    typedef struct {
        int          due;
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev_rdy = 1'b0;

    multdiv_unit dut (
        .clock          (clk),
        .reset          (rst),
        .data_operandA  (opa),
        .data_operandB  (opb),
        .ctrl_MULT      (mult),
        .ctrl_DIV       (div),
        .data_result    (res),
        .data_exception (exc),
        .data_resultRDY (rdy),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint p;
        int     q;
        if (m) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p != longint'($signed(p[31:0])));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            q = $signed(a) / $signed(b);
            r = q;
            e = 1'b0;
        end
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return $urandom_range(0, 20) - 10;
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; the strobe is sampled on the following posedge (E0).
    task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input bit track);
        exp_t        e;
        logic [31:0] r;
        logic        x;
        mult = m;
        div  = d;
        opa  = a;
        opb  = b;
        if (track) begin
            model(m, a, b, r, x);
            e.due = cyc + 34;
            e.res = r;
            e.exc = x;
            sb.push_back(e);
        end
        @(negedge clk);
        mult = 1'b0;
        div  = 1'b0;
        opa  = $urandom;
        opb  = $urandom;
    endtask

    task automatic run(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        issue(m, d, a, b, 1'b1);
        repeat (33) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rdy) begin
            check("busy_during_rdy", {31'd0, busy}, 32'd0);
            check("rdy_single_cycle", {31'd0, prev_rdy}, 32'd0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rdy: got RDY with result %h at cycle %0d, required none", res, cyc);
            end else begin
                e = sb.pop_front();
                check("rdy_cycle", cyc, e.due);
                check("result", res, e.res);
                check("exception", {31'd0, exc}, {31'd0, e.exc});
            end
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
            n_checks++;
            n_fail++;
            $display("FAIL missing_rdy: got no RDY by cycle %0d, required at cycle %0d", cyc, sb[0].due);
            e = sb.pop_front();
        end
        prev_rdy = rdy;
    end

    initial begin
        bit do_abort;
        bit m;
        bit d;
        rst  = 1'b1;
        mult = 1'b0;
        div  = 1'b0;
        opa  = 32'd0;
        opb  = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_result", res, 32'd0);
        check("reset_exception", {31'd0, exc}, 32'd0);
        check("reset_rdy", {31'd0, rdy}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 7 x -3 with busy tracked through every iteration cycle
        issue(1'b1, 1'b0, 32'd7, -32'sd3, 1'b1);
        for (int i = 0; i < 32; i++) begin
            check("busy_in_flight", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        check("busy_last_iter", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("busy_after_done", {31'd0, busy}, 32'd0);

        run(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        run(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1);
        run(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run(1'b0, 1'b1, -32'sd7, 32'd2);
        run(1'b0, 1'b1, 32'd100, -32'sd10);
        run(1'b0, 1'b1, 32'd5, 32'd0);
        run(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run(1'b0, 1'b1, 32'h8000_0000, 32'd1);

        // MULT aborted by a DIV start on E10
        issue(1'b1, 1'b0, 32'd3, 32'd4, 1'b0);
        repeat (9) @(negedge clk);
        run(1'b0, 1'b1, 32'd20, 32'd4);

        // Both strobes: multiply wins
        run(1'b1, 1'b1, 32'd6, 32'd3);

        // Restart coincident with the finishing edge suppresses that RDY
        issue(1'b0, 1'b1, 32'd1000, 32'd7, 1'b0);
        repeat (32) @(negedge clk);
        run(1'b1, 1'b0, 32'd5, 32'd6);

        // Asynchronous reset between E15 and E16
        issue(1'b1, 1'b0, 32'd123, 32'd456, 1'b0);
        repeat (15) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midreset_result", res, 32'd0);
        check("midreset_exception", {31'd0, exc}, 32'd0);
        check("midreset_rdy", {31'd0, rdy}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run(1'b1, 1'b0, 32'd2, 32'd2);

        for (int i = 0; i < 60; i++) begin
            do_abort = (i < 59) && ($urandom % 5 == 0);
            m = $urandom % 2;
            d = !m || ($urandom % 4 == 0);
            if (do_abort) begin
                issue(m, d, pick(), pick(), 1'b0);
                repeat ($urandom_range(0, 32)) @(negedge clk);
            end else begin
                run(m, d, pick(), pick());
            end
        end

        repeat (40) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
